// File: rtl/cpu16_div.sv
// cpu16_div: iterative restoring divider, one quotient bit per clock.
//   clk, reset   : clock, synchronous active-high reset
//   start        : request, accepted only while busy==0
//   sgn          : two's-complement divide (only with CPU16_DIV_SIGNED_EN defined)
//   x, y         : dividend / divisor, sampled on the accepting edge
//   busy         : high from the cycle after acceptance through the done cycle
//   done         : one-cycle pulse, q/r/dz valid in this cycle
//   q, r, dz     : quotient, remainder, divide-by-zero flag; held until next start
// Optional feature macro: CPU16_DIV_SIGNED_EN (signed divide via sgn).
module cpu16_div #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dz
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state, state_d;
    logic [WIDTH-1:0]   dvd, dvd_d;
    logic [WIDTH-1:0]   rem, rem_d;
    logic [WIDTH-1:0]   dsr, dsr_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               neg_q, neg_q_d, neg_r, neg_r_d;
    logic               busy_d, done_d, dz_d;
    logic [WIDTH-1:0]   q_d, r_d;

    // Operand sign handling
    logic               sx_c, sy_c;
    logic [WIDTH-1:0]   ax_c, ay_c;
`ifdef CPU16_DIV_SIGNED_EN
    assign sx_c = sgn & x[WIDTH-1];
    assign sy_c = sgn & y[WIDTH-1];
`else
    logic unused_sgn;
    assign unused_sgn = sgn;
    assign sx_c = 1'b0;
    assign sy_c = 1'b0;
`endif
    assign ax_c = sx_c ? ({WIDTH{1'b0}} - x) : x;
    assign ay_c = sy_c ? ({WIDTH{1'b0}} - y) : y;

    // One restoring step; the shifted remainder needs WIDTH+1 bits when |y| > 2^(WIDTH-1)
    logic [WIDTH:0]     rem_sh_c;
    logic               rem_ge_c;
    logic [WIDTH-1:0]   rem_nx_c, dvd_nx_c, q_fix_c, r_fix_c;
    logic [WIDTH:0]     rem_sub_c;

    assign rem_sh_c  = {rem, dvd[WIDTH-1]};
    assign rem_ge_c  = rem_sh_c >= {1'b0, dsr};
    assign rem_sub_c = rem_sh_c - {1'b0, dsr};
    assign rem_nx_c  = rem_ge_c ? rem_sub_c[WIDTH-1:0] : rem_sh_c[WIDTH-1:0];
    assign dvd_nx_c  = {dvd[WIDTH-2:0], rem_ge_c};
    assign q_fix_c   = neg_q ? ({WIDTH{1'b0}} - dvd_nx_c) : dvd_nx_c;
    assign r_fix_c   = neg_r ? ({WIDTH{1'b0}} - rem_nx_c) : rem_nx_c;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            dvd   <= '0;
            rem   <= '0;
            dsr   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            q     <= '0;
            r     <= '0;
            dz    <= 1'b0;
        end else begin
            state <= state_d;
            dvd   <= dvd_d;
            rem   <= rem_d;
            dsr   <= dsr_d;
            cnt   <= cnt_d;
            neg_q <= neg_q_d;
            neg_r <= neg_r_d;
            busy  <= busy_d;
            done  <= done_d;
            q     <= q_d;
            r     <= r_d;
            dz    <= dz_d;
        end
    end

    // Next state and next register values; results land on the edge entering FIN
    always_comb begin
        state_d = state;
        dvd_d   = dvd;
        rem_d   = rem;
        dsr_d   = dsr;
        cnt_d   = cnt;
        neg_q_d = neg_q;
        neg_r_d = neg_r;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        q_d     = q;
        r_d     = r;
        dz_d    = dz;
        case (state)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (y == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        q_d     = '1;
                        r_d     = x;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                        dvd_d   = ax_c;
                        dsr_d   = ay_c;
                        rem_d   = '0;
                        cnt_d   = '0;
                        neg_q_d = sx_c ^ sy_c;
                        neg_r_d = sx_c;
                    end
                end
            end
            RUN: begin
                busy_d = 1'b1;
                dvd_d  = dvd_nx_c;
                rem_d  = rem_nx_c;
                cnt_d  = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    q_d     = q_fix_c;
                    r_d     = r_fix_c;
                    dz_d    = 1'b0;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
